// File: rtl/tile_prog_loader_pkg.sv
// Shared encodings for the tile program loader: FSM states, idle bus values
// and instruction-type codes.
package tile_prog_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PROG   = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_RUN    = 2'd3;

    localparam logic [63:0] NOP_INSTR = 64'h5;
    localparam logic [7:0]  NO_TARGET = 8'hFF;

    typedef enum logic [2:0] {
        IT_NOP    = 3'b000,
        IT_LOAD   = 3'b001,
        IT_STORE  = 3'b010,
        IT_ALU    = 3'b011,
        IT_BRANCH = 3'b100,
        IT_SYNC   = 3'b101
    } instr_type_e;

endpackage

// File: rtl/tile_prog_loader_slot_counters.sv
// Per-tile saturating instruction-slot counters; reports whether the tile
// addressed by idx is already full. Out-of-range ids touch nothing.
module tile_slot_counters #(
    parameter int NUM_TILES  = 16,
    parameter int IMEM_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       inc,
    input  logic [7:0] idx,
    output logic       full
);

    localparam int            CW  = $clog2(IMEM_DEPTH + 1);
    localparam logic [CW-1:0] MAX = CW'(IMEM_DEPTH);

    logic [NUM_TILES-1:0][CW-1:0] cnt;
    logic [NUM_TILES-1:0]         sel;
    logic [NUM_TILES-1:0]         at_max;

    for (genvar i = 0; i < NUM_TILES; i++) begin : g_tile
        assign sel[i]    = (idx == 8'(i));
        assign at_max[i] = (cnt[i] == MAX);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_TILES; i++) begin
            if (!reset || clear)
                cnt[i] <= '0;
            else if (inc && sel[i] && !at_max[i])
                cnt[i] <= cnt[i] + 1'b1;
        end
    end

    assign full = |(sel & at_max);

endmodule

// File: rtl/tile_prog_loader.sv
// Tile array program loader: streams instructions onto the broadcast bus,
// settles, runs the array, returns to program mode. TILE_ID_RANGE_CHECK_EN
// drops out-of-range tile ids and adds the sticky err_bad_id output.
import tile_prog_pkg::*;

module tile_prog_loader #(
    parameter int NUM_TILES     = 16,
    parameter int IMEM_DEPTH    = 8,
    parameter int SETTLE_CYCLES = 2,
    parameter int RUN_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [RUN_W-1:0] run_len,
    input  logic             halt,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_target_id,
    input  logic [63:0]      s_instr,
    input  logic             s_last,
    output logic             program_mode,
    output logic [7:0]       target_id,
    output logic [63:0]      instruction,
    output logic             instr_strobe,
    output logic             busy,
    output logic             done,
    output logic             err_overflow
`ifdef TILE_ID_RANGE_CHECK_EN
    ,
    output logic             err_bad_id
`endif
);

    localparam int            SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    logic [1:0]       state;
    logic [SW-1:0]    settle_cnt;
    logic [RUN_W-1:0] run_cnt;
    logic             accept;
    logic             slot_full;
    logic             drop_id;

    assign s_ready      = (state == ST_PROG);
    assign busy         = (state != ST_IDLE);
    assign program_mode = (state != ST_RUN);
    assign accept       = s_valid && s_ready;

`ifdef TILE_ID_RANGE_CHECK_EN
    localparam logic [8:0] TILE_LIM = 9'(NUM_TILES);
    assign drop_id = ({1'b0, s_target_id} >= TILE_LIM);
`else
    assign drop_id = 1'b0;
`endif

    tile_slot_counters #(
        .NUM_TILES (NUM_TILES),
        .IMEM_DEPTH(IMEM_DEPTH)
    ) u_slots (
        .clk  (clk),
        .reset(reset),
        .clear((state == ST_IDLE) && start),
        .inc  (accept),
        .idx  (s_target_id),
        .full (slot_full)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_IDLE;
            target_id    <= NO_TARGET;
            instruction  <= NOP_INSTR;
            instr_strobe <= 1'b0;
            done         <= 1'b0;
            err_overflow <= 1'b0;
            settle_cnt   <= '0;
            run_cnt      <= '0;
`ifdef TILE_ID_RANGE_CHECK_EN
            err_bad_id   <= 1'b0;
`endif
        end else begin
            instr_strobe <= 1'b0;
            done         <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    state        <= ST_PROG;
                    err_overflow <= 1'b0;
`ifdef TILE_ID_RANGE_CHECK_EN
                    err_bad_id   <= 1'b0;
`endif
                end
                ST_PROG: if (accept) begin
                    if (slot_full) begin
                        err_overflow <= 1'b1;
                    end else if (drop_id) begin
`ifdef TILE_ID_RANGE_CHECK_EN
                        err_bad_id <= 1'b1;
`endif
                    end else begin
                        target_id    <= s_target_id;
                        instruction  <= s_instr;
                        instr_strobe <= 1'b1;
                    end
                    // A dropped last word still closes the session.
                    if (s_last) begin
                        if (SETTLE_CYCLES == 0) begin
                            state   <= ST_RUN;
                            run_cnt <= run_len;
                        end else begin
                            state      <= ST_SETTLE;
                            settle_cnt <= '0;
                        end
                    end
                end
                ST_SETTLE: begin
                    target_id   <= NO_TARGET;
                    instruction <= NOP_INSTR;
                    if (settle_cnt == SETTLE_LAST) begin
                        state   <= ST_RUN;
                        run_cnt <= run_len;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                default: begin
                    // run_len of 0 or 1 both give a single RUN cycle.
                    if (halt || run_cnt < RUN_W'(2)) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end else begin
                        run_cnt <= run_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tile_prog_loader.sv
// Bench for tile_prog_loader: table of directed sessions, hand-written reset
// sequence, then random sessions checked against a slot-occupancy model.
module tb_tile_prog_loader;

    localparam int NUM_TILES     = 16;
    localparam int IMEM_DEPTH    = 8;
    localparam int SETTLE_CYCLES = 2;
    localparam int RUN_W         = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [RUN_W-1:0] run_len = '0;
    logic             halt = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [7:0]       s_target_id = '0;
    logic [63:0]      s_instr = '0;
    logic             s_last = 1'b0;
    logic             program_mode;
    logic [7:0]       target_id;
    logic [63:0]      instruction;
    logic             instr_strobe;
    logic             busy;
    logic             done;
    logic             err_overflow;
`ifdef TILE_ID_RANGE_CHECK_EN
    logic             err_bad_id;
`endif

    tile_prog_loader #(
        .NUM_TILES(NUM_TILES), .IMEM_DEPTH(IMEM_DEPTH),
        .SETTLE_CYCLES(SETTLE_CYCLES), .RUN_W(RUN_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .run_len(run_len), .halt(halt),
        .s_valid(s_valid), .s_ready(s_ready), .s_target_id(s_target_id),
        .s_instr(s_instr), .s_last(s_last), .program_mode(program_mode),
        .target_id(target_id), .instruction(instruction),
        .instr_strobe(instr_strobe), .busy(busy), .done(done),
        .err_overflow(err_overflow)
`ifdef TILE_ID_RANGE_CHECK_EN
        , .err_bad_id(err_bad_id)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    int slots[NUM_TILES];
    bit m_ovf;
    bit m_bad;

    typedef struct {
        int tid; int nw; int rl; int hat;
        int exp_strobes; int exp_ovf; int exp_low;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // One full session: start, nw words (tid_fix<0 picks random ids), then run.
    task automatic session(input int tid_fix, input int nw, input int rl, input int hat,
                           output int nstrobe, output int low);
        logic [7:0]  tid;
        logic [63:0] ins;
        logic [7:0]  last_t;
        logic [63:0] last_i;
        bit bc, seen_done;
        int pre, eff, exp_low;
        nstrobe = 0;
        low = 0;
        pre = 0;
        seen_done = 0;
        last_t = '0;
        last_i = '0;
        for (int t = 0; t < NUM_TILES; t++) slots[t] = 0;
        m_ovf = 0;
        m_bad = 0;
        @(negedge clk); start = 1'b1; run_len = RUN_W'(rl);
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < nw; i++) begin
            tid = (tid_fix < 0) ? 8'($urandom_range(0, 19)) : 8'(tid_fix);
            ins = {$urandom(), 24'h0, 8'hA1 + 8'(i)};
            bc = 1;
            if (int'(tid) < NUM_TILES) begin
                if (slots[tid] >= IMEM_DEPTH) begin bc = 0; m_ovf = 1; end
                else slots[tid]++;
            end else begin
`ifdef TILE_ID_RANGE_CHECK_EN
                bc = 0; m_bad = 1;
`endif
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            s_valid = 1'b1; s_target_id = tid; s_instr = ins; s_last = (i == nw - 1);
            chk("s_ready", s_ready, 1);
            @(posedge clk);
            @(negedge clk);
            s_valid = 1'b0; s_last = 1'b0;
            if (instr_strobe) nstrobe++;
            chk("strobe", instr_strobe, bc);
            if (bc) begin
                chk("bus_target", target_id, tid);
                chk("bus_instr", instruction, ins);
            end
            chk("ovf_word", err_overflow, m_ovf);
        end
        // The last word's strobe cycle was the first settle cycle.
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            halt = 1'b0;
            if (program_mode) begin
                if (low > 0) begin
                    chk("done_pulse", done, 1);
                    chk("busy_fall", busy, 0);
                    seen_done = 1;
                    break;
                end
                pre++;
                last_t = target_id;
                last_i = instruction;
            end else begin
                low++;
                if (low == hat) halt = 1'b1;
            end
        end
        chk("run_finished", seen_done, 1);
        @(negedge clk);
        chk("done_single", done, 0);
        chk("settle_len", pre, SETTLE_CYCLES - 1);
        chk("settle_tid", last_t, 8'hFF);
        chk("settle_ins", last_i, 64'h5);
        eff = (rl < 1) ? 1 : rl;
        exp_low = (hat > 0 && hat < eff) ? hat : eff;
        chk("run_len", low, exp_low);
        chk("ovf_sticky", err_overflow, m_ovf);
`ifdef TILE_ID_RANGE_CHECK_EN
        chk("bad_id", err_bad_id, m_bad);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int ns, lo;
        tbl[0] = '{4, 3, 5, 0, 3, 0, 5};
        tbl[1] = '{2, 9, 5, 0, 8, 1, 5};
        tbl[2] = '{2, 8, 0, 0, 8, 0, 1};
        tbl[3] = '{7, 2, 100, 3, 2, 0, 3};
`ifdef TILE_ID_RANGE_CHECK_EN
        tbl[4] = '{20, 2, 3, 0, 0, 0, 3};
`else
        tbl[4] = '{20, 2, 3, 0, 2, 0, 3};
`endif
        tbl[5] = '{15, 1, 1, 1, 1, 0, 1};

        repeat (2) @(negedge clk);
        chk("rst_pm", program_mode, 1);
        chk("rst_tid", target_id, 8'hFF);
        chk("rst_ins", instruction, 64'h5);
        chk("rst_strobe", instr_strobe, 0);
        chk("rst_ready", s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", err_overflow, 0);
        reset = 1'b1;

        for (int k = 0; k < 6; k++) begin
            session(tbl[k].tid, tbl[k].nw, tbl[k].rl, tbl[k].hat, ns, lo);
            chk("tbl_strobes", ns, tbl[k].exp_strobes);
            chk("tbl_ovf", err_overflow, tbl[k].exp_ovf);
            chk("tbl_low", lo, tbl[k].exp_low);
        end

        // Reset in PROG with a handshake in flight.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1; s_target_id = 8'd3; s_instr = 64'(i + 16);
            @(negedge clk);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("mid_pm", program_mode, 1);
        chk("mid_tid", target_id, 8'hFF);
        chk("mid_ins", instruction, 64'h5);
        chk("mid_strobe", instr_strobe, 0);
        chk("mid_ready", s_ready, 0);
        chk("mid_busy", busy, 0);
        s_valid = 1'b0;
        reset = 1'b1;
        session(3, 8, 2, 0, ns, lo);
        chk("mid_strobes", ns, 8);
        chk("mid_ovf", err_overflow, 0);

        for (int r = 0; r < 20; r++) begin
            int nw, rl, hat;
            nw  = $urandom_range(1, 12);
            rl  = $urandom_range(0, 8);
            hat = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 8) : 0;
            session(-1, nw, rl, hat, ns, lo);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tile_prog_loader.md
Name: tile_prog_loader

Overview:
- Upstream sequencer for the tile array; owns the `program_mode` / `target_id` / `instruction` broadcast bus that every tile samples.
- Accepts a stream of (target tile, 64-bit instruction) words over a valid/ready handshake and tracks per-tile instruction-slot occupancy.
- After the last word it holds a settle window, drops `program_mode` to run the array for a bounded number of cycles, then returns the array to program mode.

Parameters:
- NUM_TILES, 16, number of tiles on the broadcast bus; valid tile ids are 0..NUM_TILES-1.
- IMEM_DEPTH, 8, instruction slots per tile.
- SETTLE_CYCLES, 2, cycles `program_mode` stays high after the last accepted word.
- RUN_W, 16, width of the run-length counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load session from IDLE.
- run_len  in  RUN_W  execution cycles; sampled when entering RUN.
- halt  in  1  ends RUN early.
- s_valid  in  1  input word valid.
- s_ready  out  1  loader can accept a word.
- s_target_id  in  8  destination tile.
- s_instr  in  64  instruction word.
- s_last  in  1  marks the final word of the session.
- program_mode  out  1  broadcast to tiles; 1 = program, 0 = execute.
- target_id  out  8  broadcast target id.
- instruction  out  64  broadcast instruction.
- instr_strobe  out  1  one-cycle pulse, high when the bus carries a fresh word.
- busy  out  1  high when state is not IDLE.
- done  out  1  one-cycle pulse on RUN→IDLE.
- err_overflow  out  1  sticky; a word was dropped because its tile's slots were full.

Behaviour:
- Reset values: state IDLE, program_mode=1, target_id=8'hFF, instruction=64'h5 (nop), instr_strobe=0, s_ready=0, busy=0, done=0, err_overflow=0, all slot counters 0, run counter 0.
- IDLE:
  - s_ready=0.
  - start=1 → PROG; clears all slot counters and err_overflow.
- PROG:
  - s_ready=1.
  - Handshake is s_valid & s_ready.
  - An accepted word is registered onto target_id/instruction with instr_strobe=1 the next cycle (latency 1).
  - The addressed tile's slot counter increments.
  - If that counter already equals IMEM_DEPTH: word dropped, bus unchanged, instr_strobe=0, err_overflow set; s_last still honoured.
  - Accepted word with s_last=1 → SETTLE.
  - Bus holds its last value between accepts.
  - start is ignored outside IDLE.
- SETTLE:
  - s_ready=0; program_mode=1.
  - Bus driven to target_id=8'hFF, instruction=64'h5, so no tile matches.
  - Counts SETTLE_CYCLES, then → RUN.
  - SETTLE_CYCLES=0 goes directly to RUN.
- RUN:
  - program_mode=0.
  - Run counter loads run_len on entry and decrements each cycle.
  - Exits when the counter reaches 1 or halt=1; run_len=0 exits after one RUN cycle.
  - halt and counter expiry in the same cycle: single exit, single done pulse.
  - Exit → IDLE with program_mode=1 in the same edge and done=1 for one cycle.
- Slot counters:
  - One per tile, width clog2(IMEM_DEPTH+1).
  - Saturate at IMEM_DEPTH; never wrap.
- s_target_id ≥ NUM_TILES: word is broadcast, and no counter is touched (without the optional feature below).
- Reset mid-session (any state): immediate return to reset values on the next edge; an in-flight handshake is discarded.
- Tiles restart their instruction pointers on each program_mode edge; the loader guarantees every program_mode transition is a clean single-edge change.

Optional Feature:
- Macro: TILE_ID_RANGE_CHECK_EN.
- Defined:
  - s_target_id ≥ NUM_TILES is accepted (s_ready handshake completes) but dropped: no broadcast, no strobe.
  - Adds a sticky output err_bad_id, reset 0, cleared on start.
- Undefined: out-of-range ids are broadcast as normal and the err_bad_id port is absent.

Decomposition:
- Package tile_prog_pkg holds:
  - state encoding: IDLE=2'd0, PROG=2'd1, SETTLE=2'd2, RUN=2'd3;
  - NOP_INSTR=64'h5;
  - NO_TARGET=8'hFF;
  - instruction-type constants 3'b000..3'b101.
- One natural sub-module: tile_slot_counters, a NUM_TILES-entry saturating counter array with clear, increment-by-index and a full flag for the indexed tile.

Test Plan:
- Basic load:
  - Stimulus: reset low 2 cycles, then start; 3 words to tile 4 (instr 0x..A1, A2, A3), last on the third.
  - Response: three instr_strobe pulses with target_id=4, one cycle after each handshake; SETTLE 2 cycles with bus=FF/0x5; then program_mode=0.
- Overflow:
  - Stimulus: 9 words to tile 2.
  - Response: 8 strobes; 9th dropped; err_overflow=1 from the cycle after it; session still completes.
- Run length:
  - Stimulus: run_len=5, no halt.
  - Response: program_mode low for exactly 5 cycles; done pulses once; busy falls with done.
- Halt:
  - Stimulus: run_len=100, halt asserted on the 3rd RUN cycle.
  - Response: program_mode returns to 1 on the next edge; done=1 once.
- Reset mid-PROG:
  - Stimulus: reset low after 2 accepted words.
  - Response: all outputs at reset values next cycle; a subsequent start sees clear counters (8 more words accepted for the same tile without overflow).
- Range check (TILE_ID_RANGE_CHECK_EN defined):
  - Stimulus: s_target_id=20 with NUM_TILES=16.
  - Response: no strobe; err_bad_id=1.
